// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor capture path and its frame scheduler.
package sensor_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_DRAIN = 3'd2,
        S_CLEAR = 3'd3,
        S_WAIT  = 3'd4
    } sched_state_e;

    localparam int SENSOR_DEPTH  = 64;
    localparam int SENSOR_ADDR_W = 6;

    // Byte offsets of the scheduler registers inside the slave wrapper window.
    localparam logic [7:0] SCHED_CTRL_OFS   = 8'h40;
    localparam logic [7:0] SCHED_PERIOD_OFS = 8'h44;
    localparam logic [7:0] SCHED_STATUS_OFS = 8'h48;
    localparam logic [7:0] SCHED_FRAMES_OFS = 8'h4C;

endpackage

// File: rtl/sensor_sched_timer.sv
// Idle-period down-counter; expire flags the last cycle of a loaded period.
module sensor_sched_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] load_val,
    output logic                expire
);
    import sensor_pkg::*;

    logic [PERIOD_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == PERIOD_W'(1));

endmodule

// File: rtl/sensor_sched.sv
// Frame scheduler: arms sensor capture, drains the buffer as a valid/ready stream, clears, repeats.
module sensor_sched
    import sensor_pkg::*;
#(
    parameter int DEPTH    = SENSOR_DEPTH,
    parameter int ADDR_W   = SENSOR_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic                cfg_cont,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                int_ack,
    output logic                busy_o,
    output logic                done_int_o,
    output logic [15:0]         frames_o,
    output logic                sctrl_en_o,
    output logic                sctrl_clear_o,
    output logic [ADDR_W-1:0]   sctrl_addr_o,
    input  logic                sctrl_int_i,
    input  logic [DATA_W-1:0]   sctrl_out_i,
    output logic                out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic                out_last_o,
    input  logic                out_ready_i
);

    sched_state_e        state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [15:0]         frames_reg, frames_next;
    logic                done_reg, done_next;
    logic                cont_reg, cont_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic                stop_pend_reg, stop_pend_next;
    logic                timer_load, timer_en, timer_expire;
    logic                draining, handshake;

    sensor_sched_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (period_reg),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            frames_reg    <= '0;
            done_reg      <= 1'b0;
            cont_reg      <= 1'b0;
            period_reg    <= '0;
            stop_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            frames_reg    <= frames_next;
            done_reg      <= done_next;
            cont_reg      <= cont_next;
            period_reg    <= period_next;
            stop_pend_reg <= stop_pend_next;
        end
    end

    assign draining  = (state_reg == S_DRAIN);
    assign handshake = draining & out_ready_i;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        frames_next    = frames_reg;
        cont_next      = cont_reg;
        period_next    = period_reg;
        stop_pend_next = stop_pend_reg;
        done_next      = int_ack ? 1'b0 : done_reg;
        timer_load     = 1'b0;
        timer_en       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (cfg_start) begin
                    cont_next      = cfg_cont;
                    period_next    = cfg_period;
                    stop_pend_next = 1'b0;
                    state_next     = S_ARM;
                end
            end
            S_ARM: begin
                // An interrupt arriving with a stop still drains the captured frame.
                if (sctrl_int_i) begin
                    idx_next   = '0;
                    state_next = S_DRAIN;
                    if (cfg_stop) stop_pend_next = 1'b1;
                end else if (cfg_stop) begin
                    stop_pend_next = 1'b1;
                    state_next     = S_CLEAR;
                end
            end
            S_DRAIN: begin
                if (cfg_stop) stop_pend_next = 1'b1;
                if (handshake) begin
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == ADDR_W'(DEPTH - 1)) begin
                        frames_next = frames_reg + 1'b1;
                        state_next  = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                // A stop landing on the clear cycle itself is honoured rather than lost.
                if (cont_reg && !stop_pend_reg && !cfg_stop) begin
                    timer_load = 1'b1;
                    state_next = (period_reg != '0) ? S_WAIT : S_ARM;
                end else begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                timer_en = 1'b1;
                if (cfg_stop) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (timer_expire) begin
                    state_next = S_ARM;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy_o        = (state_reg != S_IDLE);
    assign done_int_o    = done_reg;
    assign frames_o      = frames_reg;
    assign sctrl_en_o    = (state_reg == S_ARM);
    assign sctrl_clear_o = (state_reg == S_CLEAR);
    assign sctrl_addr_o  = draining ? idx_reg : '0;
    assign out_valid_o   = draining;
    assign out_last_o    = draining && (idx_reg == ADDR_W'(DEPTH - 1));
    assign out_data_o    = draining ? sctrl_out_i : '0;

endmodule

// File: tb/tb_sensor_sched.sv
// Self-checking bench for sensor_sched: control-vector table plus scoreboarded stream frames.
module tb_sensor_sched;
    localparam int DEPTH = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int PERIOD_W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_start = 1'b0, cfg_stop = 1'b0, cfg_cont = 1'b0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic                int_ack = 1'b0;
    logic                busy, done_int, sctrl_en, sctrl_clear, sctrl_int = 1'b0;
    logic [15:0]         frames;
    logic [ADDR_W-1:0]   sctrl_addr;
    logic [DATA_W-1:0]   sctrl_out, out_data;
    logic                out_valid, out_last, out_ready = 1'b1;
    logic [31:0]         buf_base = 32'h0;

    int n_checks = 0;
    int n_fail = 0;
    int clr_cnt = 0;
    int beat_cnt = 0;
    bit bp_mode = 0;

    always #5 clk = ~clk;

    assign sctrl_out = buf_base + 32'(sctrl_addr);

    sensor_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_cont(cfg_cont),
        .cfg_period(cfg_period), .int_ack(int_ack), .busy_o(busy), .done_int_o(done_int),
        .frames_o(frames), .sctrl_en_o(sctrl_en), .sctrl_clear_o(sctrl_clear),
        .sctrl_addr_o(sctrl_addr), .sctrl_int_i(sctrl_int), .sctrl_out_i(sctrl_out),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sb_q[$];

    typedef struct packed {
        logic        start, stop, cont;
        logic [15:0] period;
        logic        ack;
        logic        busy, en, clr, valid, done;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.data = base + 32'(i);
            b.last = (i == DEPTH - 1);
            sb_q.push_back(b);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return !busy;
            1: return sctrl_clear;
            default: return sctrl_en;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max, input string name);
        int k = 0;
        while (!cond(sel) && k < max) begin
            step();
            k++;
        end
        if (!cond(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, got 0 want 1", name, max);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 0; cfg_stop = 0; int_ack = 0; sctrl_int = 0;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
        clr_cnt = 0;
    endtask

    task automatic start(input logic cont, input logic [15:0] period);
        cfg_start = 1; cfg_cont = cont; cfg_period = period;
        step();
        cfg_start = 0;
    endtask

    task automatic fire_int(input logic [31:0] base);
        buf_base = base;
        push_frame(base);
        sctrl_int = 1;
        step();
        sctrl_int = 0;
    endtask

    // Ready generator: always high, or high one cycle in three under backpressure.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            out_ready = bp_mode ? ((cnt % 3) == 0) : 1'b1;
        end
    end

    // Stream monitor: scoreboard pop on each handshake, stability check while stalled.
    initial begin
        bit prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 0;
        beat_t b;
        forever begin
            @(negedge clk);
            if (sctrl_clear) clr_cnt++;
            if (!rst && prev_stall && out_valid) begin
                check("stall_data_stable", out_data, prev_data);
                check("stall_last_stable", 32'(out_last), 32'(prev_last));
            end
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    b = sb_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", 32'(out_last), 32'(b.last));
                    beat_cnt++;
                end
            end
            prev_stall = !rst && out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        int n;
        //          start stop cont period ack | busy en clr valid done
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        buf_base = 32'hDEAD0000;
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done_int), 0);
        check("rst_frames", 32'(frames), 0);
        check("rst_en", 32'(sctrl_en), 0);
        check("rst_clear", 32'(sctrl_clear), 0);
        check("rst_addr", 32'(sctrl_addr), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_last", 32'(out_last), 0);
        $display("txn reset: outputs sampled after reset");

        // Control table: start/stop/ack interplay without draining a frame
        for (int r = 0; r < 14; r++) begin
            cfg_start = tbl[r].start; cfg_stop = tbl[r].stop; int_ack = tbl[r].ack;
            if (tbl[r].start) begin
                cfg_cont = tbl[r].cont;
                cfg_period = tbl[r].period;
            end
            step();
            cfg_start = 0; cfg_stop = 0; int_ack = 0;
            check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            check($sformatf("tbl%0d_en", r), 32'(sctrl_en), 32'(tbl[r].en));
            check($sformatf("tbl%0d_clear", r), 32'(sctrl_clear), 32'(tbl[r].clr));
            check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].valid));
            check($sformatf("tbl%0d_done", r), 32'(done_int), 32'(tbl[r].done));
            check($sformatf("tbl%0d_frames", r), 32'(frames), 0);
            $display("txn table row %0d: busy=%0d en=%0d clr=%0d done=%0d", r, busy, sctrl_en, sctrl_clear, done_int);
        end

        // Single frame, ready high
        do_reset();
        start(1'b0, 16'd0);
        for (int i = 0; i < 10; i++) step();
        fire_int(32'h1000);
        check("int_latency_valid", 32'(out_valid), 1);
        check("int_latency_en", 32'(sctrl_en), 0);
        check("int_latency_addr", 32'(sctrl_addr), 0);
        wait_for(0, 200, "single_idle");
        check("single_clear_cycles", clr_cnt, 1);
        check("single_done", 32'(done_int), 1);
        check("single_frames", 32'(frames), 1);
        check("single_sb_empty", sb_q.size(), 0);
        $display("txn single frame: frames=%0d done=%0d", frames, done_int);

        // Backpressure with one-in-three ready
        do_reset();
        bp_mode = 1;
        start(1'b0, 16'd0);
        fire_int(32'h2000);
        wait_for(0, 600, "bp_idle");
        bp_mode = 0;
        check("bp_frames", 32'(frames), 1);
        check("bp_sb_empty", sb_q.size(), 0);
        $display("txn backpressure frame: frames=%0d", frames);

        // Continuous, period 5, three frames, then stop in ARM
        do_reset();
        start(1'b1, 16'd5);
        for (int f = 0; f < 3; f++) begin
            wait_for(2, 50, "cont5_arm");
            fire_int(32'h4000 + 32'(f) * 32'h100);
            wait_for(1, 200, "cont5_clear");
            n = 0;
            step();
            while (!sctrl_en && n < 50) begin
                n++;
                step();
            end
            check("cont5_wait_cycles", n, 5);
            $display("txn continuous frame %0d: wait cycles=%0d", f, n);
        end
        cfg_stop = 1;
        step();
        cfg_stop = 0;
        check("arm_stop_clear", 32'(sctrl_clear), 1);
        step();
        check("arm_stop_idle", 32'(busy), 0);
        check("cont5_frames", 32'(frames), 3);
        check("cont5_done", 32'(done_int), 1);
        check("cont5_sb_empty", sb_q.size(), 0);

        // Continuous, period 0: straight back to ARM
        do_reset();
        start(1'b1, 16'd0);
        for (int f = 0; f < 2; f++) begin
            fire_int(32'h5000 + 32'(f) * 32'h100);
            wait_for(1, 200, "cont0_clear");
            step();
            check("cont0_arm_after_clear", 32'(sctrl_en), 1);
            $display("txn period-0 frame %0d: en=%0d", f, sctrl_en);
        end
        check("cont0_frames", 32'(frames), 2);

        // Stop mid-DRAIN: frame completes, then IDLE
        do_reset();
        start(1'b1, 16'd2);
        fire_int(32'h6000);
        for (int i = 0; i < 10; i++) step();
        cfg_stop = 1;
        step();
        cfg_stop = 0;
        check("drain_stop_still_busy", 32'(out_valid), 1);
        wait_for(0, 200, "drain_stop_idle");
        check("drain_stop_frames", 32'(frames), 1);
        check("drain_stop_done", 32'(done_int), 1);
        check("drain_stop_sb_empty", sb_q.size(), 0);
        $display("txn stop mid-drain: frames=%0d", frames);

        // Interrupt and stop together in ARM
        do_reset();
        start(1'b1, 16'd2);
        cfg_stop = 1;
        fire_int(32'h7000);
        cfg_stop = 0;
        check("int_stop_drain", 32'(out_valid), 1);
        wait_for(0, 200, "int_stop_idle");
        check("int_stop_frames", 32'(frames), 1);
        check("int_stop_done", 32'(done_int), 1);
        check("int_stop_sb_empty", sb_q.size(), 0);
        $display("txn int+stop: frames=%0d", frames);

        // Stop in WAIT
        do_reset();
        start(1'b1, 16'd5);
        fire_int(32'h8000);
        wait_for(1, 200, "wait_stop_clear");
        step();
        step();
        check("wait_stop_in_wait", 32'(busy), 1);
        cfg_stop = 1;
        step();
        cfg_stop = 0;
        check("wait_stop_idle", 32'(busy), 0);
        check("wait_stop_done", 32'(done_int), 1);
        check("wait_stop_frames", 32'(frames), 1);
        $display("txn stop in wait: busy=%0d", busy);

        // Reset mid-DRAIN at idx 20, then a fresh frame
        start(1'b0, 16'd0);
        fire_int(32'h9000);
        n = 0;
        while (sctrl_addr != 6'd20 && n < 100) begin
            step();
            n++;
        end
        check("mid_reset_reached_20", 32'(sctrl_addr), 20);
        rst = 1;
        step();
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_done", 32'(done_int), 0);
        check("mid_reset_frames", 32'(frames), 0);
        check("mid_reset_en", 32'(sctrl_en), 0);
        check("mid_reset_clear", 32'(sctrl_clear), 0);
        check("mid_reset_addr", 32'(sctrl_addr), 0);
        check("mid_reset_valid", 32'(out_valid), 0);
        check("mid_reset_data", out_data, 0);
        check("mid_reset_last", 32'(out_last), 0);
        rst = 0;
        sb_q.delete();
        start(1'b0, 16'd0);
        fire_int(32'hA000);
        check("fresh_first_addr", 32'(sctrl_addr), 0);
        wait_for(0, 200, "fresh_idle");
        check("fresh_frames", 32'(frames), 1);
        check("fresh_sb_empty", sb_q.size(), 0);
        $display("txn reset mid-drain + fresh frame: frames=%0d beats=%0d", frames, beat_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
